arbitro_escrita_banco: RTL

Write-port controller for the 32×32 register bank. It shares the bank's single write port between three sources: UC writeback, the IN-instruction path from the board switches, and a debug/loader port. It also sequences the IN handshake: it stalls the UC until the operator confirms a switch value, then writes that value to the target register. It sits between the UC, the I/O switches and the bank's write inputs.

---
 rtl/arbitro_escrita_pkg.sv | 20 ++
 rtl/detector_borda.sv | 25 ++
 rtl/arbitro_escrita_banco.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/arbitro_escrita_pkg.sv
// Shared types and default widths for the register-bank write-port arbiter.
package arbitro_escrita_pkg;

  localparam int unsigned LARGURA_DADO_PADRAO = 32;
  localparam int unsigned LARGURA_END_PADRAO  = 5;

  typedef enum logic [1:0] {
    OCIOSO         = 2'd0,
    ESPERA_ENTRADA = 2'd1,
    CONCLUI        = 2'd2
  } estado_t;

  typedef enum logic [1:0] {
    FONTE_NENHUMA = 2'd0,
    FONTE_UC      = 2'd1,
    FONTE_SWITCH  = 2'd2,
    FONTE_DBG     = 2'd3
  } fonte_t;

endpackage

// File: rtl/detector_borda.sv
// Two-flop synchroniser for an asynchronous level followed by a rising-edge pulse.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic pulso
);

  logic sinc1_q, sinc2_q, anterior_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc1_q    <= 1'b0;
      sinc2_q    <= 1'b0;
      anterior_q <= 1'b0;
    end else begin
      sinc1_q    <= entrada;
      sinc2_q    <= sinc1_q;
      anterior_q <= sinc2_q;
    end
  end

  assign pulso = sinc2_q & ~anterior_q;

endmodule

// File: rtl/arbitro_escrita_banco.sv
// Shares the bank write port between UC writeback, the IN/switch path and a debug port.
// Optional REG_ZERO_PROTEGIDO_EN suppresses the bank write enable for address 0.
module arbitro_escrita_banco
  import arbitro_escrita_pkg::*;
#(
  parameter int unsigned LARGURA_DADO = LARGURA_DADO_PADRAO,
  parameter int unsigned LARGURA_END  = LARGURA_END_PADRAO
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ucEscreve,
  input  logic                    ucEntrada,
  input  logic [LARGURA_END-1:0]  ucEndereco,
  input  logic [LARGURA_DADO-1:0] ucDado,
  input  logic [LARGURA_DADO-1:0] switchDado,
  input  logic                    switchConfirma,
  input  logic                    dbgEscreve,
  input  logic [LARGURA_END-1:0]  dbgEndereco,
  input  logic [LARGURA_DADO-1:0] dbgDado,
  output logic                    bancoEscreve,
  output logic [LARGURA_END-1:0]  bancoEndereco,
  output logic [LARGURA_DADO-1:0] bancoDado,
  output logic                    ucParada,
  output logic                    dbgAceito,
  output logic                    estadoEntrada
);

  estado_t                estado_q, estado_d;
  fonte_t                 fonte;
  logic [LARGURA_END-1:0] end_in_q, end_in_d;
  logic                   vez_dbg_q, vez_dbg_d;
  logic                   entrada_d;
  logic                   parada, aceito;
  logic                   confirma_pulso;
  logic                   escreve_d;
  logic [LARGURA_END-1:0] endereco_d;
  logic [LARGURA_DADO-1:0] dado_d;

  detector_borda u_detector_borda (
    .clock   (clock),
    .reset   (reset),
    .entrada (switchConfirma),
    .pulso   (confirma_pulso)
  );

  always_comb begin
    estado_d  = estado_q;
    entrada_d = estadoEntrada;
    end_in_d  = end_in_q;
    vez_dbg_d = vez_dbg_q;
    fonte     = FONTE_NENHUMA;
    parada    = 1'b0;
    aceito    = 1'b0;
    case (estado_q)
      OCIOSO: begin
        if (ucEntrada) begin
          parada    = 1'b1;
          end_in_d  = ucEndereco;
          estado_d  = ESPERA_ENTRADA;
          entrada_d = 1'b1;
          // The port carries no UC write this cycle, so debug may use it.
          if (dbgEscreve) begin
            fonte  = FONTE_DBG;
            aceito = 1'b1;
          end
        end else if (ucEscreve && dbgEscreve) begin
          vez_dbg_d = ~vez_dbg_q;
          if (vez_dbg_q) begin
            fonte  = FONTE_DBG;
            aceito = 1'b1;
            parada = 1'b1;
          end else begin
            fonte = FONTE_UC;
          end
        end else if (ucEscreve) begin
          fonte = FONTE_UC;
        end else if (dbgEscreve) begin
          fonte  = FONTE_DBG;
          aceito = 1'b1;
        end
      end
      ESPERA_ENTRADA: begin
        parada = 1'b1;
        if (confirma_pulso) begin
          fonte     = FONTE_SWITCH;
          estado_d  = CONCLUI;
          entrada_d = 1'b0;
        end else if (dbgEscreve) begin
          fonte  = FONTE_DBG;
          aceito = 1'b1;
        end
      end
      CONCLUI: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d  = OCIOSO;
        entrada_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    escreve_d  = 1'b1;
    endereco_d = bancoEndereco;
    dado_d     = bancoDado;
    case (fonte)
      FONTE_UC: begin
        endereco_d = ucEndereco;
        dado_d     = ucDado;
      end
      FONTE_SWITCH: begin
        endereco_d = end_in_q;
        dado_d     = switchDado;
      end
      FONTE_DBG: begin
        endereco_d = dbgEndereco;
        dado_d     = dbgDado;
      end
      default: escreve_d = 1'b0;
    endcase
`ifdef REG_ZERO_PROTEGIDO_EN
    if (endereco_d == '0) escreve_d = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q      <= OCIOSO;
      end_in_q      <= '0;
      vez_dbg_q     <= 1'b0;
      estadoEntrada <= 1'b0;
      bancoEscreve  <= 1'b0;
      bancoEndereco <= '0;
      bancoDado     <= '0;
    end else begin
      estado_q      <= estado_d;
      end_in_q      <= end_in_d;
      vez_dbg_q     <= vez_dbg_d;
      estadoEntrada <= entrada_d;
      bancoEscreve  <= escreve_d;
      bancoEndereco <= endereco_d;
      bancoDado     <= dado_d;
    end
  end

  // Handshake outputs are forced low while reset is held.
  assign ucParada  = parada & reset;
  assign dbgAceito = aceito & reset;

endmodule
